// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - push-button edge/long-press event queue with round-robin output arbiter
module button_event_arbiter #(
  parameter int          N_BTN      = 4,
  parameter logic [15:0] LONG_TICKS = 16'd2048
) (
  input  logic             clk_1024,
  input  logic             reset_n,
  input  logic             debounce_cfg,
  input  logic [N_BTN-1:0] btn_flag,
  output logic [N_BTN-1:0] debounce_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic [N_BTN-1:0] pending,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int PW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic             valid_nxt;
  logic [7:0]       code_nxt;
  logic             deb_q;
  logic [1:0]       win_cnt;
  logic             in_win;
  logic [N_BTN-1:0] flag_q, flag_qq;
  logic [15:0]      hold_cnt [N_BTN];
  logic [N_BTN-1:0] press_pend, long_pend, rel_pend;
  logic [N_BTN-1:0] press_clr, long_clr, rel_clr;
  logic [N_BTN-1:0] rise, fall, long_set;
  logic             drop;
  logic [15:0]      pend_ext, press_ext, long_ext;
  logic [4:0]       idx, nxt;
  logic [3:0]       sel;
  logic             found;
  logic [1:0]       kind;

  assign in_win      = (win_cnt != 2'd0);
  assign debounce_en = {N_BTN{deb_q}};
  assign pending     = press_pend | long_pend | rel_pend;

  // Event detection is suppressed for the whole resync window.
  always_comb begin
    rise     = flag_q & ~flag_qq & {N_BTN{~in_win}};
    fall     = ~flag_q & flag_qq & {N_BTN{~in_win}};
    long_set = '0;
    for (int i = 0; i < N_BTN; i++) begin
      long_set[i] = ~in_win & flag_q[i] & (hold_cnt[i] == LONG_TICKS - 16'd2);
    end
    drop = (|(rise & press_pend & ~press_clr)) |
           (|(long_set & long_pend & ~long_clr)) |
           (|(fall & rel_pend & ~rel_clr));
  end

  always_ff @(posedge clk_1024 or negedge reset_n) begin
    if (!reset_n) begin
      deb_q      <= 1'b0;
      win_cnt    <= 2'd0;
      flag_q     <= '0;
      flag_qq    <= '0;
      press_pend <= '0;
      long_pend  <= '0;
      rel_pend   <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < N_BTN; i++) hold_cnt[i] <= 16'd0;
    end else begin
      deb_q <= debounce_cfg;
      if (debounce_cfg != deb_q)
        win_cnt <= 2'd2;
      else if (in_win)
        win_cnt <= win_cnt - 2'd1;
      flag_q  <= btn_flag;
      // Inside the window flag_qq tracks the incoming flag so no edge survives it.
      flag_qq <= in_win ? btn_flag : flag_q;
      for (int i = 0; i < N_BTN; i++) begin
        if (in_win || !flag_q[i])
          hold_cnt[i] <= 16'd0;
        else if (hold_cnt[i] != LONG_TICKS)
          hold_cnt[i] <= hold_cnt[i] + 16'd1;
      end
      press_pend <= rise | (press_pend & ~press_clr);
      long_pend  <= long_set | (long_pend & ~long_clr);
      rel_pend   <= fall | (rel_pend & ~rel_clr);
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_1024 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      evt_valid <= valid_nxt;
      evt_code  <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    valid_nxt = evt_valid;
    code_nxt  = evt_code;
    press_clr = '0;
    long_clr  = '0;
    rel_clr   = '0;
    pend_ext  = 16'(pending);
    press_ext = 16'(press_pend);
    long_ext  = 16'(long_pend);
    idx       = 5'd0;
    nxt       = 5'd0;
    sel       = 4'd0;
    found     = 1'b0;
    kind      = 2'b00;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        for (int off = 0; off < N_BTN; off++) begin
          idx = 5'(ptr) + 5'(off);
          if (idx >= 5'(N_BTN)) idx = idx - 5'(N_BTN);
          if (!found && pend_ext[idx[3:0]]) begin
            found = 1'b1;
            sel   = idx[3:0];
          end
        end
        if (found) begin
          if (press_ext[sel])     kind = 2'b01;
          else if (long_ext[sel]) kind = 2'b10;
          else                    kind = 2'b11;
          for (int j = 0; j < N_BTN; j++) begin
            press_clr[j] = (sel == 4'(j)) && (kind == 2'b01);
            long_clr[j]  = (sel == 4'(j)) && (kind == 2'b10);
            rel_clr[j]   = (sel == 4'(j)) && (kind == 2'b11);
          end
          code_nxt  = {kind, 2'b00, sel};
          valid_nxt = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          nxt = {1'b0, evt_code[3:0]} + 5'd1;
          if (nxt >= 5'(N_BTN)) nxt = 5'd0;
          ptr_nxt   = nxt[PW-1:0];
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - scoreboard bench for button_event_arbiter
module tb_button_event_arbiter;

  logic       clk_1024 = 1'b0;
  logic       reset_n = 1'b0;
  logic       debounce_cfg = 1'b0;
  logic [3:0] btn_flag = 4'h0;
  logic [3:0] debounce_en;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic [3:0] pending;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  button_event_arbiter #(.N_BTN(4), .LONG_TICKS(16'd2048)) dut (
    .clk_1024     (clk_1024),
    .reset_n      (reset_n),
    .debounce_cfg (debounce_cfg),
    .btn_flag     (btn_flag),
    .debounce_en  (debounce_en),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk_1024 = ~clk_1024;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1024);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick(1);
      t++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    tick(4);
  endtask

  // A transfer happens on the next rising edge whenever valid and ready are both high here.
  always @(negedge clk_1024) begin
    if (reset_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) check("evt_extra", {24'h0, evt_code}, 32'h100);
      else                   check("evt_code", {24'h0, evt_code}, {24'h0, exp_q.pop_front()});
    end
  end

  initial begin
    tick(2);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 8'h00);
    check("rst_pending", pending, 4'h0);
    check("rst_overflow", overflow, 0);
    check("rst_deb_en", debounce_en, 4'h0);
    reset_n = 1'b1;
    tick(2);

    // single press, latency
    evt_ready = 1'b1;
    exp_q.push_back(8'h40);
    btn_flag[0] = 1'b1;
    tick(1);
    check("t1_valid_k", evt_valid, 0);
    tick(1);
    check("t1_pend_k1", pending, 4'h1);
    check("t1_valid_k1", evt_valid, 0);
    tick(1);
    check("t1_valid_k2", evt_valid, 1);
    check("t1_code_k2", evt_code, 8'h40);
    tick(1);
    check("t1_pend_k3", pending, 4'h0);
    exp_q.push_back(8'hC0);
    btn_flag[0] = 1'b0;
    drain();

    // long press on button 2
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h82);
    exp_q.push_back(8'hC2);
    btn_flag[2] = 1'b1;
    tick(1);
    tick(2046);
    check("t2_long_early", pending[2], 0);
    tick(1);
    check("t2_long_set", pending[2], 1);
    tick(53);
    btn_flag[2] = 1'b0;
    drain();

    // round robin from ptr=0, then wrap after button 3
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h40 + 8'(i));
    btn_flag = 4'hF;
    drain();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + 8'(i));
    btn_flag = 4'h0;
    drain();
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h43);
    btn_flag = 4'b1001;
    drain();
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC3);
    btn_flag = 4'h0;
    drain();

    // back-pressure and overflow
    evt_ready = 1'b0;
    btn_flag[1] = 1'b1;
    tick(3);
    check("t4_valid", evt_valid, 1);
    check("t4_code", evt_code, 8'h41);
    btn_flag[1] = 1'b0;
    tick(3);
    btn_flag[1] = 1'b1;
    tick(3);
    check("t4_ovf_clear", overflow, 0);
    check("t4_code_held", evt_code, 8'h41);
    btn_flag[1] = 1'b0;
    tick(2);
    check("t4_ovf_set", overflow, 1);
    check("t4_pend", pending[1], 1);
    check("t4_code_held2", evt_code, 8'h41);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("t4_ovf_clr", overflow, 0);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'hC1);
    evt_ready = 1'b1;
    drain();

    // debounce_cfg change masks edges in the resync window
    debounce_cfg = 1'b1;
    tick(1);
    check("t5_deb_en1", debounce_en, 4'hF);
    btn_flag[0] = 1'b1;
    tick(10);
    check("t5_pend1", pending, 4'h0);
    check("t5_valid1", evt_valid, 0);
    debounce_cfg = 1'b0;
    tick(1);
    check("t5_deb_en0", debounce_en, 4'h0);
    btn_flag[0] = 1'b0;
    tick(10);
    check("t5_pend0", pending, 4'h0);
    check("t5_valid0", evt_valid, 0);

    // asynchronous reset during OFFER
    evt_ready = 1'b0;
    btn_flag[2] = 1'b1;
    tick(3);
    check("t6_valid", evt_valid, 1);
    btn_flag[2] = 1'b0;
    tick(3);
    btn_flag[2] = 1'b1;
    tick(3);
    btn_flag[2] = 1'b0;
    tick(3);
    check("t6_ovf", overflow, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_code", evt_code, 8'h00);
    check("t6_rst_pending", pending, 4'h0);
    check("t6_rst_ovf", overflow, 0);
    tick(2);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    tick(2);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h43);
    btn_flag = 4'b1001;
    drain();
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC3);
    btn_flag = 4'h0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
